// File: rtl/fft4_frame_seq.sv
// ---------------------------------------------------------------------------
// fft4_frame_seq
//
// Streaming sequencer around a 4-point DFT butterfly. It collects four complex
// samples (A, B, C, D) one per input handshake, computes all four bins in a
// single registered CALC cycle, and then streams X0..X3 out under
// valid/ready backpressure.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : in_re/in_im carry a valid sample
//   in_ready   : sequencer accepts a sample this cycle (LOAD only)
//   in_re/im   : sample real / imaginary part (W-bit two's complement)
//   out_valid  : out_re/out_im/out_idx carry a valid bin (OUT only)
//   out_ready  : consumer accepts the bin this cycle
//   out_re/im  : bin real / imaginary part
//   out_idx    : bin index k of X[k]
//   out_last   : high with out_valid on the final bin (k == 3)
//   busy       : frame in progress (CALC, OUT, or LOAD with samples held)
//   frame_cnt  : completed frames, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module fft4_frame_seq #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_re,
    input  logic [W-1:0]     in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_re,
    output logic [W-1:0]     out_im,
    output logic [1:0]       out_idx,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         li_q, li_d;     // next sample slot to fill
    logic [1:0]         oi_q, oi_d;     // bin currently presented
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [W-1:0]       smp_re_q [4];
    logic [W-1:0]       smp_im_q [4];
    logic [W-1:0]       res_re_q [4];
    logic [W-1:0]       res_im_q [4];

    logic [W-1:0]       bf_re [4];
    logic [W-1:0]       bf_im [4];

    logic               in_hs;
    logic               calc_en;

    // -----------------------------------------------------------------------
    // Next-state / handshake logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        li_d      = li_q;
        oi_d      = oi_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        calc_en   = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // 2-bit index wraps to 0 after slot D is written.
                    li_d = li_q + 2'd1;
                    if (li_q == 2'd3) begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                calc_en = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    oi_d = oi_q + 2'd1;
                    if (oi_q == 2'd3) begin
                        state_d = ST_LOAD;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    assign in_hs = in_valid & in_ready;

    // -----------------------------------------------------------------------
    // Radix-4 butterfly on the held frame. All arithmetic stays at W bits and
    // wraps; multiplying by -j maps (r, i) to (i, -r).
    // -----------------------------------------------------------------------
    always_comb begin
        logic [W-1:0] ar, ai, br, bi, cr, ci, dr, di;
        ar = smp_re_q[0];  ai = smp_im_q[0];
        br = smp_re_q[1];  bi = smp_im_q[1];
        cr = smp_re_q[2];  ci = smp_im_q[2];
        dr = smp_re_q[3];  di = smp_im_q[3];

        bf_re[0] = ar + br + cr + dr;
        bf_im[0] = ai + bi + ci + di;
        bf_re[1] = ar + bi - cr - di;
        bf_im[1] = ai - br - ci + dr;
        bf_re[2] = ar - br + cr - dr;
        bf_im[2] = ai - bi + ci - di;
        bf_re[3] = ar - bi - cr + di;
        bf_im[3] = ai + br - ci - dr;
    end

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            li_q    <= 2'd0;
            oi_q    <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            li_q    <= li_d;
            oi_q    <= oi_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Sample and result banks. Samples persist across frames; results change
    // only in CALC, so OUT data is immune to input activity.
    // -----------------------------------------------------------------------
    // NOTE: these small banks are flops, not RAM, so they take the async reset
    // and come up as all-zero; a RAM-style array would be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                smp_re_q[i] <= '0;
                smp_im_q[i] <= '0;
                res_re_q[i] <= '0;
                res_im_q[i] <= '0;
            end
        end else begin
            if (in_hs) begin
                smp_re_q[li_q] <= in_re;
                smp_im_q[li_q] <= in_im;
            end
            if (calc_en) begin
                for (int i = 0; i < 4; i++) begin
                    res_re_q[i] <= bf_re[i];
                    res_im_q[i] <= bf_im[i];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Bin data is gated to zero outside OUT; while stalled, oi_q and
    // the result bank are frozen, so the presented bin holds stable.
    // -----------------------------------------------------------------------
    assign out_re    = out_valid ? res_re_q[oi_q] : '0;
    assign out_im    = out_valid ? res_im_q[oi_q] : '0;
    assign out_idx   = oi_q;
    assign out_last  = out_valid && (oi_q == 2'd3);
    assign busy      = (state_q != ST_LOAD) || (li_q != 2'd0);
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_fft4_frame_seq.sv
// ---------------------------------------------------------------------------
// tb_fft4_frame_seq
//
// Directed and randomized bench for fft4_frame_seq. Expected bins come from a
// direct DFT summation X[k] = sum_n x[n] * (-j)^(n*k) at W-bit wrap.
// ---------------------------------------------------------------------------
module tb_fft4_frame_seq;

    localparam int W     = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_re;
    logic [W-1:0]     in_im;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_re;
    logic [W-1:0]     out_im;
    logic [1:0]       out_idx;
    logic             out_last;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;

    fft4_frame_seq #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [W-1:0]     smp_re [4];
    logic [W-1:0]     smp_im [4];
    logic [W-1:0]     exp_re [4];
    logic [W-1:0]     exp_im [4];
    logic [CNT_W-1:0] exp_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: rotate each sample by (-j)^(n*k) and accumulate.
    function automatic void model();
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] sr, si, r, i, t;
            sr = '0;
            si = '0;
            for (int n = 0; n < 4; n++) begin
                r = smp_re[n];
                i = smp_im[n];
                for (int q = 0; q < (n * k) % 4; q++) begin
                    t = r;
                    r = i;
                    i = -t;
                end
                sr = sr + r;
                si = si + i;
            end
            exp_re[k] = sr;
            exp_im[k] = si;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] re, input logic [W-1:0] im);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_frame(input bit gaps);
        model();
        for (int n = 0; n < 4; n++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send(smp_re[n], smp_im[n]);
        end
    endtask

    task automatic collect(input bit rnd);
        int k;
        int t;
        k = 0;
        t = 0;
        while (k < 4 && t < 200) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                check("bin_idx",  64'(out_idx),  64'(k));
                check("bin_re",   64'(out_re),   64'(exp_re[k]));
                check("bin_im",   64'(out_im),   64'(exp_im[k]));
                check("bin_last", 64'(out_last), 64'(k == 3));
                check("in_ready_out", 64'(in_ready), 64'd0);
                if (out_ready) k++;
            end
            tick();
            t++;
        end
        out_ready = 1'b1;
        check("bins_done", 64'(k), 64'd4);
        exp_cnt = exp_cnt + CNT_W'(1);
        check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    endtask

    task automatic set_frame(input logic [W-1:0] ar, ai, br, bi, cr, ci, dr, di);
        smp_re[0] = ar; smp_im[0] = ai;
        smp_re[1] = br; smp_im[1] = bi;
        smp_re[2] = cr; smp_im[2] = ci;
        smp_re[3] = dr; smp_im[3] = di;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
        exp_cnt   = '0;
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_out_idx",   64'(out_idx),   64'd0);
        check("rst_out_re",    64'(out_re),    64'd0);
        check("rst_out_im",    64'(out_im),    64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);

        // Impulse.
        set_frame(1, 0, 0, 0, 0, 0, 0, 0);
        load_frame(0);
        collect(0);

        // DC, with exact latency of the first bin.
        set_frame(1, 0, 1, 0, 1, 0, 1, 0);
        load_frame(0);
        check("lat_calc_valid", 64'(out_valid), 64'd0);
        check("lat_calc_busy",  64'(busy),      64'd1);
        tick();
        check("lat_x0_valid",   64'(out_valid), 64'd1);
        collect(0);

        // B = 1 only.
        set_frame(0, 0, 1, 0, 0, 0, 0, 0);
        load_frame(0);
        collect(0);

        // Full-scale positive samples wrap in X0.
        set_frame(32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0);
        load_frame(0);
        check("wrap_model_x0", 64'(exp_re[0]), 64'hFFFF_FFFC);
        collect(0);

        // Backpressure at bin 1 with ignored input pulses.
        for (int n = 0; n < 4; n++) begin
            smp_re[n] = $urandom();
            smp_im[n] = $urandom();
        end
        load_frame(0);
        tick();
        check("bp_x0_idx", 64'(out_idx), 64'd0);
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_re    = $urandom();
            in_im    = $urandom();
            check("bp_idx",      64'(out_idx),   64'd1);
            check("bp_re",       64'(out_re),    64'(exp_re[1]));
            check("bp_im",       64'(out_im),    64'(exp_im[1]));
            check("bp_valid",    64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready),  64'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            check("bp_rel_idx", 64'(out_idx), 64'(k));
            check("bp_rel_re",  64'(out_re),  64'(exp_re[k]));
            check("bp_rel_im",  64'(out_im),  64'(exp_im[k]));
            tick();
        end
        exp_cnt = exp_cnt + CNT_W'(1);
        check("bp_frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
        // A following frame confirms no stalled-phase sample slipped in.
        for (int n = 0; n < 4; n++) begin
            smp_re[n] = $urandom();
            smp_im[n] = $urandom();
        end
        load_frame(0);
        collect(0);

        // Reset in the middle of a partial frame.
        send($urandom(), $urandom());
        send($urandom(), $urandom());
        check("abort_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_cnt",   64'(frame_cnt), 64'd0);
        tick();
        rst     = 1'b0;
        exp_cnt = '0;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_busy",     64'(busy),     64'd0);
        for (int c = 0; c < 3; c++) begin
            check("abort_no_out", 64'(out_valid), 64'd0);
            tick();
        end
        set_frame(2, 3, 0, 0, 0, 0, 0, 0);
        load_frame(0);
        collect(0);

        // Randomized frames with input gaps and output stalls.
        for (int f = 0; f < 20; f++) begin
            for (int n = 0; n < 4; n++) begin
                smp_re[n] = $urandom();
                smp_im[n] = $urandom();
            end
            load_frame(1);
            collect(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
